// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the 4-digit BCD counter slice: the BCD digit type,
// its legal bounds and a clamp helper that forces any nibble into 0..9.
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Nibbles above 9 are not BCD; they saturate to 9 rather than wrapping.
  function automatic bcd_digit_t bcd_clamp(input logic [3:0] nibble);
    bcd_digit_t v_out;
    if (nibble > BCD_MAX) begin
      v_out = BCD_MAX;
    end else begin
      v_out = nibble;
    end
    return v_out;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One BCD digit of the ripple chain. Holds a registered digit in 0..9 and
// produces a combinational carry (up) / borrow (down) for the next digit.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset (digit -> 0)
//   i_step     advance this digit by one in direction i_dir
//   i_dir      1 = up, 0 = down
//   i_load     synchronous parallel load (clamped to 9)
//   i_clear    synchronous clear to 0 (wins over load and step)
//   i_load_val raw nibble to load
//   o_digit    registered BCD digit
//   o_carry    i_step & (up ? digit==9 : digit==0)
// -----------------------------------------------------------------------------
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_step,
  input  logic       i_dir,
  input  logic       i_load,
  input  logic       i_clear,
  input  logic [3:0] i_load_val,
  output bcd_digit_t o_digit,
  output logic       o_carry
);

  bcd_digit_t r_digit;
  bcd_digit_t w_next;

  // Carry/borrow fires only when this digit rolls over on a step.
  assign o_carry = i_step & (i_dir ? (r_digit == BCD_MAX) : (r_digit == BCD_MIN));
  assign o_digit = r_digit;

  // Next digit value for a count step; out-of-range values fold back into 0..9.
  always_comb begin
    w_next = r_digit;
    if (i_step) begin
      if (i_dir) begin
        if (r_digit >= BCD_MAX) begin
          w_next = BCD_MIN;
        end else begin
          w_next = r_digit + 4'd1;
        end
      end else begin
        if ((r_digit == BCD_MIN) || (r_digit > BCD_MAX)) begin
          w_next = BCD_MAX;
        end else begin
          w_next = r_digit - 4'd1;
        end
      end
    end else begin
      w_next = r_digit;
    end
  end

  // Digit register: clear > load > step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit <= BCD_MIN;
    end else if (i_clear) begin
      r_digit <= BCD_MIN;
    end else if (i_load) begin
      r_digit <= bcd_clamp(i_load_val);
    end else begin
      r_digit <= w_next;
    end
  end

endmodule

// File: rtl/bcd_counter_4digit.sv
// -----------------------------------------------------------------------------
// bcd_counter_4digit
// Four-digit BCD up/down counter with programmable prescaler. Drives the
// d3..d0 BCD digit bus. Digits, tick and wrap all change one cycle after the
// clock edge on which the prescaler sits at its terminal count with en high.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous, active-high reset
//   en        count/prescaler enable; low freezes prescaler and digits
//   up_dn     1 = count up, 0 = count down (sampled on the step cycle)
//   clear     synchronous clear to 0000 (highest priority)
//   load      synchronous parallel load of load_val, nibbles clamped to 9
//   load_val  {d3,d2,d1,d0} nibbles to load
//   d0..d3    registered BCD digits (ones .. thousands)
//   tick      one-cycle pulse per prescaler period
//   wrap      one-cycle pulse on 9999->0000 (up) or 0000->9999 (down)
// -----------------------------------------------------------------------------
module bcd_counter_4digit
  import bcd_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up_dn,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [3:0]  d0,
  output logic [3:0]  d1,
  output logic [3:0]  d2,
  output logic [3:0]  d3,
  output logic        tick,
  output logic        wrap
);

  localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TERM = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          r_wrap;
  logic          w_term;
  logic [3:0]    w_step;
  logic [3:0]    w_carry;
  bcd_digit_t    w_digit [4];

  // Terminal count of the prescaler is the step strobe for the whole chain.
  assign w_term = en & (r_presc == PRESC_TERM);

  // Digit 0 steps on the terminal count; each higher digit steps on the
  // carry/borrow of the one below, so the full ripple settles in one cycle.
  assign w_step = {w_carry[2:0], w_term};

  for (genvar g = 0; g < 4; g++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .i_step     (w_step[g]),
      .i_dir      (up_dn),
      .i_load     (load),
      .i_clear    (clear),
      .i_load_val (load_val[4*g +: 4]),
      .o_digit    (w_digit[g]),
      .o_carry    (w_carry[g])
    );
  end

  // Prescaler and pulse registers; clear and load restart the period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (clear || load) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_tick <= w_term;
      // Carry out of the top digit already includes the step strobe.
      r_wrap <= w_carry[3];
      if (w_term) begin
        r_presc <= '0;
      end else if (en) begin
        r_presc <= r_presc + PW'(1);
      end else begin
        r_presc <= r_presc;
      end
    end
  end

  assign d0   = w_digit[0];
  assign d1   = w_digit[1];
  assign d2   = w_digit[2];
  assign d3   = w_digit[3];
  assign tick = r_tick;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_bcd_counter_4digit.sv
// -----------------------------------------------------------------------------
// tb_bcd_counter_4digit
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against an integer reference model of the counter.
// -----------------------------------------------------------------------------
module tb_bcd_counter_4digit;

  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        up_dn;
  logic        clear;
  logic        load;
  logic [15:0] load_val;
  logic [3:0]  d0, d1, d2, d3;
  logic        tick;
  logic        wrap;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: count as a plain integer 0..9999.
  int   m_cnt;
  int   m_p;
  logic m_tick;
  logic m_wrap;

  logic [15:0] seeds [6] = '{16'h9999, 16'h9998, 16'h0000, 16'h0001, 16'h0999, 16'h1000};

  bcd_counter_4digit #(.TICK_DIV(TICK_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .d0       (d0),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .tick     (tick),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_val(input logic [15:0] raw);
    int acc = 0;
    int nib;
    for (int k = 3; k >= 0; k--) begin
      nib = int'(raw[4*k +: 4]);
      if (nib > 9) nib = 9;
      acc = acc * 10 + nib;
    end
    return acc;
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_p    = 0;
    m_tick = 1'b0;
    m_wrap = 1'b0;
  endtask

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_edge();
    if (clear) begin
      model_reset();
    end else if (load) begin
      m_cnt  = clamp_val(load_val);
      m_p    = 0;
      m_tick = 1'b0;
      m_wrap = 1'b0;
    end else begin
      m_tick = en && (m_p == TICK_DIV - 1);
      m_wrap = 1'b0;
      if (m_tick) begin
        if (up_dn) begin
          m_wrap = (m_cnt == 9999);
          m_cnt  = (m_cnt + 1) % 10000;
        end else begin
          m_wrap = (m_cnt == 0);
          m_cnt  = (m_cnt + 9999) % 10000;
        end
      end
      if (en) m_p = m_tick ? 0 : m_p + 1;
    end
  endtask

  task automatic compare_all();
    check_eq("digits", {d3, d2, d1, d0}, to_bcd(m_cnt));
    check_eq("tick", tick, m_tick);
    check_eq("wrap", wrap, m_wrap);
  endtask

  // Called at a falling edge: drive, let one rising edge pass, check.
  task automatic cycle(input logic e, input logic u, input logic c, input logic l,
                       input logic [15:0] v);
    en       = e;
    up_dn    = u;
    clear    = c;
    load     = l;
    load_val = v;
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic        e, u, c, l;
    logic [15:0] v;

    rst = 1'b1; en = 1'b0; up_dn = 1'b1; clear = 1'b0; load = 1'b0; load_val = 16'h0000;
    model_reset();
    #2;
    check_eq("reset_digits", {d3, d2, d1, d0}, 16'h0000);
    check_eq("reset_tick", tick, 1'b0);
    check_eq("reset_wrap", wrap, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Plain counting from reset: ticks every 4 enabled cycles.
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("count_0003", {d3, d2, d1, d0}, 16'h0003);
    check_eq("count_tick12", tick, 1'b1);

    // Up carry ripple and up wrap.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h0999);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("up_carry", {d3, d2, d1, d0}, 16'h1000);
    check_eq("up_carry_nowrap", wrap, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h9999);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("up_wrap_digits", {d3, d2, d1, d0}, 16'h0000);
    check_eq("up_wrap_pulse", {tick, wrap}, 2'b11);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("up_wrap_one_cycle", wrap, 1'b0);

    // Down borrow ripple and down wrap.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h1000);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    check_eq("down_borrow", {d3, d2, d1, d0}, 16'h0999);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    check_eq("down_wrap_digits", {d3, d2, d1, d0}, 16'h9999);
    check_eq("down_wrap_pulse", {tick, wrap}, 2'b11);

    // Priority and clamping.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
    check_eq("clear_over_load", {d3, d2, d1, d0}, 16'h0000);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'hFA3C);
    check_eq("load_clamp", {d3, d2, d1, d0}, 16'h9939);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("after_load_no_tick", tick, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("after_load_tick", tick, 1'b1);
    check_eq("after_load_digits", {d3, d2, d1, d0}, 16'h9940);

    // Enable gating: prescaler holds its partial count.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("gated_frozen", {d3, d2, d1, d0}, 16'h0000);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("resume_no_tick", tick, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("resume_tick", tick, 1'b1);
    check_eq("resume_digits", {d3, d2, d1, d0}, 16'h0001);

    // Asynchronous reset on the prescaler terminal cycle.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h9998);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    en = 1'b1; up_dn = 1'b1; clear = 1'b0; load = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_digits", {d3, d2, d1, d0}, 16'h0000);
    check_eq("async_rst_pulses", {tick, wrap}, 2'b00);
    model_reset();
    @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Randomized traffic biased towards the wrap boundaries.
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 9) != 0);
      u = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 49) == 0);
      l = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 1) == 0) v = 16'($urandom);
      else v = seeds[$urandom_range(0, 5)];
      cycle(e, u, c, l, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_counter_4digit.md
Name: bcd_counter_4digit

Overview:
Four-digit BCD up/down counter that produces the d0..d3 digit bus consumed by the alarm and display logic. A programmable prescaler divides clk into a count tick. The counter supports synchronous clear, parallel load, and wrap in both directions with a one-cycle wrap pulse. It is the source end of the 4-digit BCD bus.

Parameters:
TICK_DIV, 100000000, clk cycles per count step (≥2); 1 Hz at 100 MHz; benches use 4.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  count/prescaler enable; low freezes prescaler and digits
up_dn  input  1  1 = count up, 0 = count down; sampled on tick cycle
clear  input  1  synchronous clear to 0000
load  input  1  synchronous parallel load
load_val  input  16  {d3,d2,d1,d0} BCD nibbles to load
d0  output  4  ones digit, BCD, registered
d1  output  4  tens digit, BCD, registered
d2  output  4  hundreds digit, BCD, registered
d3  output  4  thousands digit, BCD, registered
tick  output  1  one-cycle pulse on each prescaler terminal count (en high)
wrap  output  1  one-cycle pulse when count wraps 9999->0000 (up) or 0000->9999 (down)

Behaviour:
- Reset is asynchronous, active-high (rst); clock is clk. On rst: d0..d3 = 0, prescaler = 0, tick = 0, wrap = 0.
- Prescaler: width clog2(TICK_DIV); increments each cycle while en=1; at TICK_DIV-1, returns to 0 and asserts tick that same cycle (tick is combinational from prescaler==TICK_DIV-1 && en, or registered — chosen: registered, see latency). Holds its value while en=0.
- Latency: the digit update and the tick/wrap pulses are all visible one cycle after the clk edge on which the prescaler equals TICK_DIV-1 with en=1. First tick after reset therefore follows TICK_DIV enabled cycles.
- Priority per cycle: clear > load > count step.
- clear=1: digits become 0000, prescaler becomes 0, tick=0, wrap=0. en is ignored.
- load=1 (clear=0): each nibble of load_val is clamped to 9 if >9, then written; prescaler becomes 0; tick=0, wrap=0. en is ignored.
- Count step on tick:
  - Up: d0 increments; 9 -> 0 with carry into d1; the carry ripples the same way through d3. 9999 -> 0000 asserts wrap.
  - Down: d0 decrements; 0 -> 9 with borrow into d1; the borrow ripples through d3. 0000 -> 9999 asserts wrap.
  - The whole 4-digit step completes in one cycle; no intermediate values are visible.
- Digits never leave 0..9 under any input sequence.
- up_dn may change on any cycle; only its value on the step cycle matters.
- en deasserted mid-period: prescaler holds and the remaining count resumes when en returns. No step is lost or duplicated.
- rst asserted mid-operation: immediate async return to reset values; a tick or wrap pulse in flight is cancelled.
- tick and wrap are each exactly one cycle wide; wrap is only ever asserted together with tick.

Decomposition:
- Shared package bcd_pkg: BCD_MAX = 4'd9, BCD_MIN = 4'd0, localparam typedef of a 4-bit bcd_digit type, and a clamp function bcd_clamp(nibble).
- One sub-module, bcd_digit: input step, dir, load, clear, load value; outputs digit and carry/borrow out. It is instantiated 4× in a ripple chain; carry_out = step & (dir ? digit==9 : digit==0).
- Prescaler and output pulse registers live in the top level.

Test Plan:
- Reset and count (TICK_DIV=4): rst pulse, en=1, up_dn=1 for 12 cycles -> tick pulses 4 cycles apart; digits 0000 -> 0001 -> 0002 -> 0003; wrap=0 throughout.
- Up carry/wrap: load 16'h0999, then one tick -> 1000, wrap=0. Load 16'h9999, then one tick -> 0000 and wrap=1 for exactly one cycle, coincident with tick.
- Down borrow/wrap: up_dn=0; load 16'h1000, then tick -> 0999. Load 16'h0000, then tick -> 9999 and wrap=1.
- Priority and clamping: clear=1 and load=1 (load_val=16'h1234) asserted together -> 0000. load alone with 16'hFA3C -> 9939. Prescaler is 0 after each, so the next tick arrives 4 enabled cycles later.
- en gating: deassert en after 2 prescaler counts for 10 cycles -> no tick and digits frozen. Reassert en -> tick after exactly 2 more cycles.
- Async reset mid-step: assert rst on the prescaler terminal cycle (value 9998) -> outputs go to 0000 before the next edge, and no tick or wrap pulse appears.
